branch_target_predictor: RTL

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the PC register in the fetch stage. Each cycle it looks up the current PC and supplies the `next_pc` that the PC register latches, either a predicted target or PC+4. It is trained by the resolving branch/jump in EX through a single-cycle update port. It replaces the plain PC+4 adder on the `next_pc` path; the mispredict redirect mux stays downstream in EX.

---
 rtl/branch_target_predictor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// branch_target_predictor
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// It sits in front of the PC register and supplies next_pc every cycle:
// either a predicted target or current_pc + 4. EX trains it through a
// single-cycle update port.
//
// Ports:
//   clk            in   clock, all state changes on rising edge
//   reset          in   synchronous active-high reset (clears valid, ctr = 01)
//   current_pc     in   fetch address (PC register output)
//   pred_next_pc   out  predicted next fetch address (combinational)
//   pred_taken     out  prediction redirects to stored target (combinational)
//   pred_hit       out  valid entry with matching tag for current_pc (combinational)
//   update_en      in   EX resolved a branch/JAL/JALR this cycle
//   update_pc      in   PC of the resolved control instruction
//   update_target  in   resolved target address
//   update_taken   in   actual direction (1 for jumps)
//   update_is_jump in   unconditional control transfer (JAL/JALR)
module branch_target_predictor #(
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic [31:0] pred_next_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_is_jump
);

  localparam int unsigned IDX_BITS = $clog2(NUM_ENTRIES);
  localparam int unsigned TAG_W    = 30 - IDX_BITS;
  localparam int unsigned TAG_LSB  = IDX_BITS + 2;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // Entry storage; valid/ctr are reset, tag/target are not.
  logic              valid_q  [NUM_ENTRIES];
  logic [1:0]        ctr_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]  tag_q    [NUM_ENTRIES];
  logic [31:0]       target_q [NUM_ENTRIES];

  // Lookup side
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [31:0]         lk_seq_pc;

  // Update side
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]    up_tag;
  logic                up_match;
  logic [1:0]          up_ctr_old;
  logic [1:0]          up_ctr_new;
  logic                up_wr_meta;
  logic                up_wr_tag;
  logic                up_wr_target;

  // Instruction-aligned low bits carry no information for the predictor.
  logic unused_pc_low_bits;
  assign unused_pc_low_bits = ^update_pc[1:0];

  // Combinational lookup from stored state; no write-to-read bypass.
  always_comb begin
    lk_idx    = current_pc[TAG_LSB-1:2];
    lk_tag    = current_pc[31:TAG_LSB];
    lk_seq_pc = current_pc + 32'd4;

    pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken   = pred_hit && ctr_q[lk_idx][1];
    pred_next_pc = pred_taken ? target_q[lk_idx] : lk_seq_pc;
  end

  // Training decision for the resolving instruction.
  always_comb begin
    up_idx       = update_pc[TAG_LSB-1:2];
    up_tag       = update_pc[31:TAG_LSB];
    up_ctr_old   = ctr_q[up_idx];
    up_match     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    up_ctr_new   = up_ctr_old;
    up_wr_meta   = 1'b0;
    up_wr_tag    = 1'b0;
    up_wr_target = 1'b0;

    if (update_en) begin
      if (up_match) begin
        up_wr_meta = 1'b1;
        if (update_is_jump) begin
          up_ctr_new   = CTR_STRONG_T;
          up_wr_target = 1'b1;
        end else if (update_taken) begin
          up_ctr_new   = (up_ctr_old == CTR_STRONG_T) ? CTR_STRONG_T
                                                      : up_ctr_old + 2'd1;
          up_wr_target = 1'b1;
        end else begin
          up_ctr_new   = (up_ctr_old == CTR_STRONG_NT) ? CTR_STRONG_NT
                                                       : up_ctr_old - 2'd1;
        end
      end else if (update_taken) begin
        // Allocate or replace the aliasing entry.
        up_wr_meta   = 1'b1;
        up_wr_tag    = 1'b1;
        up_wr_target = 1'b1;
        up_ctr_new   = update_is_jump ? CTR_STRONG_T : CTR_WEAK_T;
      end
    end
  end

  // Valid bits and counters: reset to invalid / weakly not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
    end else if (up_wr_meta) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= up_ctr_new;
    end
  end

  // Tags and targets: no reset needed, writes suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (up_wr_tag) begin
        tag_q[up_idx] <= up_tag;
      end
      if (up_wr_target) begin
        target_q[up_idx] <= update_target;
      end
    end
  end

endmodule
